// File: rtl/eth_rx_fcs_checker.sv
// Ethernet receive FCS checker.
// Drives the shared byte-wide crc32 engine from the PHY byte stream, delays
// the stream by five bytes so the trailing FCS can be stripped, compares the
// received FCS against the engine result and reports one status pulse per frame.
module eth_rx_fcs_checker #(
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1518
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        crc_clear,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_result,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_good,
  output logic        fcs_error,
  output logic        length_error,
  output logic [10:0] frame_length
);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_RECV      = 2'd2,
    S_DROP      = 2'd3
  } state_t;

  localparam logic [10:0] COUNT_SAT  = 11'h7FF;
  localparam logic [10:0] MIN_LEN    = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_LEN    = 11'(MAX_BYTES);
  // Four FCS bytes plus one payload byte must be buffered before any output.
  localparam logic [10:0] HIST_DEPTH = 11'd5;

  state_t      state_q, state_d;
  logic [10:0] count_q, count_d;
  logic [7:0]  b_q [HIST_DEPTH];
  logic [31:0] h_q [HIST_DEPTH];
  logic        shift_en;

  logic        rst_meta_q, rst_sync_n_q;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_first_q, out_first_d;
  logic        out_last_q, out_last_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_good_q, frame_good_d;
  logic        fcs_error_q, fcs_error_d;
  logic        length_error_q, length_error_d;
  logic [10:0] frame_length_q, frame_length_d;

  logic        too_long;
  logic        have_payload;
  logic        too_short;
  logic        fcs_match;
  logic        end_recv;
  logic        end_drop;

  // Every low rx_dv cycle clears the engine, including the cycle that ends a
  // frame, so the next frame may start right after a single idle cycle.
  assign crc_clear = ~rx_dv;
  assign crc_data  = rx_data;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this two-flop chain a real
      // two-stage shift; blocking ones would collapse it into one flop.
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  assign too_long     = (count_q >= MAX_LEN);
  assign have_payload = (count_q >= HIST_DEPTH);
  assign too_short    = (count_q < MIN_LEN);
  // FCS arrives least-significant byte first, so b3 holds bits [7:0].
  assign fcs_match    = ({b_q[0], b_q[1], b_q[2], b_q[3]} == h_q[4]);
  assign end_recv     = (state_q == S_RECV) && !rx_dv;
  assign end_drop     = (state_q == S_DROP) && !rx_dv;

  // State register.
  always_ff @(posedge clock or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q <= S_WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      S_WAIT_IDLE: if (!rx_dv) state_d = S_IDLE;
      S_IDLE:      if (rx_dv)  state_d = S_RECV;
      S_RECV: begin
        if (!rx_dv)        state_d = S_IDLE;
        else if (too_long) state_d = S_DROP;
      end
      S_DROP:      if (!rx_dv) state_d = S_IDLE;
      default:     state_d = S_WAIT_IDLE;
    endcase
  end

  // Output and datapath control: byte count, history shift, payload and status.
  always_comb begin
    count_d        = count_q;
    shift_en       = 1'b0;
    out_valid_d    = 1'b0;
    out_first_d    = 1'b0;
    out_last_d     = 1'b0;
    frame_done_d   = 1'b0;
    frame_good_d   = 1'b0;
    fcs_error_d    = 1'b0;
    length_error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          count_d  = 11'd1;
          shift_en = 1'b1;
        end
      end
      S_RECV: begin
        if (rx_dv) begin
          count_d = (count_q == COUNT_SAT) ? COUNT_SAT : count_q + 11'd1;
          if (!too_long) begin
            shift_en    = 1'b1;
            out_valid_d = have_payload;
            out_first_d = (count_q == HIST_DEPTH);
          end
        end else begin
          frame_done_d   = 1'b1;
          out_valid_d    = have_payload;
          out_last_d     = have_payload;
          out_first_d    = (count_q == HIST_DEPTH);
          fcs_error_d    = have_payload && !fcs_match;
          length_error_d = too_short;
          frame_good_d   = have_payload && fcs_match && !too_short;
        end
      end
      S_DROP: begin
        if (rx_dv) begin
          count_d = (count_q == COUNT_SAT) ? COUNT_SAT : count_q + 11'd1;
        end else begin
          frame_done_d   = 1'b1;
          length_error_d = 1'b1;
        end
      end
      default: ;
    endcase
    out_data_d     = out_valid_d ? b_q[4] : 8'h00;
    frame_length_d = (end_recv || end_drop) ? count_q : 11'd0;
  end

  // Byte counter and the five-deep byte / CRC history.
  always_ff @(posedge clock or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      count_q <= 11'd0;
      // NOTE: the history is only 5 entries, so it is cleared with the rest
      // of the state; nothing reads it before five bytes have shifted in.
      for (int i = 0; i < HIST_DEPTH; i++) begin
        b_q[i] <= 8'h00;
        h_q[i] <= 32'h0;
      end
    end else begin
      count_q <= count_d;
      if (shift_en) begin
        b_q[0] <= rx_data;
        h_q[0] <= crc_result;
        for (int i = 1; i < HIST_DEPTH; i++) begin
          b_q[i] <= b_q[i-1];
          h_q[i] <= h_q[i-1];
        end
      end
    end
  end

  // Registered payload stream and per-frame status pulses.
  always_ff @(posedge clock or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'h00;
      out_first_q    <= 1'b0;
      out_last_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_good_q   <= 1'b0;
      fcs_error_q    <= 1'b0;
      length_error_q <= 1'b0;
      frame_length_q <= 11'd0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_first_q    <= out_first_d;
      out_last_q     <= out_last_d;
      frame_done_q   <= frame_done_d;
      frame_good_q   <= frame_good_d;
      fcs_error_q    <= fcs_error_d;
      length_error_q <= length_error_d;
      frame_length_q <= frame_length_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_first    = out_first_q;
  assign out_last     = out_last_q;
  assign frame_done   = frame_done_q;
  assign frame_good   = frame_good_q;
  assign fcs_error    = fcs_error_q;
  assign length_error = length_error_q;
  assign frame_length = frame_length_q;

endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// Bench for eth_rx_fcs_checker: two instances (MIN_BYTES=13 and default 64)
// share one byte stream; each has its own behavioural crc32 engine.
module tb_eth_rx_fcs_checker;

  localparam int K_DIGITS  = 0;
  localparam int K_PATTERN = 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_dv;
  logic [7:0]  rx_data;

  logic [1:0]  crc_clear_s;
  logic [7:0]  crc_data_s [2];
  logic [31:0] crc_result_s [2];
  logic [1:0]  out_valid_s, out_first_s, out_last_s;
  logic [1:0]  frame_done_s, frame_good_s, fcs_error_s, length_error_s;
  logic [7:0]  out_data_s [2];
  logic [10:0] frame_length_s [2];

  always #5 clock = ~clock;

  eth_rx_fcs_checker #(.MIN_BYTES(13), .MAX_BYTES(1518)) dut_a (
    .clock(clock), .reset_n(reset_n), .rx_dv(rx_dv), .rx_data(rx_data),
    .crc_clear(crc_clear_s[0]), .crc_data(crc_data_s[0]), .crc_result(crc_result_s[0]),
    .out_valid(out_valid_s[0]), .out_data(out_data_s[0]), .out_first(out_first_s[0]),
    .out_last(out_last_s[0]), .frame_done(frame_done_s[0]), .frame_good(frame_good_s[0]),
    .fcs_error(fcs_error_s[0]), .length_error(length_error_s[0]),
    .frame_length(frame_length_s[0])
  );

  eth_rx_fcs_checker dut_b (
    .clock(clock), .reset_n(reset_n), .rx_dv(rx_dv), .rx_data(rx_data),
    .crc_clear(crc_clear_s[1]), .crc_data(crc_data_s[1]), .crc_result(crc_result_s[1]),
    .out_valid(out_valid_s[1]), .out_data(out_data_s[1]), .out_first(out_first_s[1]),
    .out_last(out_last_s[1]), .frame_done(frame_done_s[1]), .frame_good(frame_good_s[1]),
    .fcs_error(fcs_error_s[1]), .length_error(length_error_s[1]),
    .frame_length(frame_length_s[1])
  );

  // Reflected CRC-32 (poly 0xEDB88320), one byte.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Engine models: register cleared by crc_clear, result combinational.
  logic [31:0] eng_q [2];
  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n || crc_clear_s[i]) eng_q[i] <= 32'hFFFFFFFF;
      else                            eng_q[i] <= crc_step(eng_q[i], crc_data_s[i]);
    end
  end
  always_comb begin
    for (int i = 0; i < 2; i++) crc_result_s[i] = ~crc_step(eng_q[i], crc_data_s[i]);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor state.
  typedef struct {
    int          n_pay;
    int          n_first;
    int          first_bad;
    int          n_last;
    int          last_bad;
    bit          good;
    bit          fcs;
    bit          lerr;
    logic [10:0] flen;
  } done_t;

  done_t       done_a[$];
  done_t       done_b[$];
  logic [7:0]  exp_stream[$];
  int          exp_idx [2];
  int          acc_pay [2], acc_first [2], acc_first_bad [2], acc_last [2], acc_last_bad [2];
  int          data_err [2], stray [2], ev_cnt [2];
  int          clr_err = 0;
  bit          mon_ignore = 1'b0;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        acc_pay[i] = 0; acc_first[i] = 0; acc_first_bad[i] = 0;
        acc_last[i] = 0; acc_last_bad[i] = 0;
        exp_idx[i] = exp_stream.size();
      end else begin
        if (out_valid_s[i] || frame_done_s[i]) ev_cnt[i]++;
        if (rx_dv && crc_clear_s[i]) clr_err++;
        if (crc_data_s[i] !== rx_data) clr_err++;
        if (!mon_ignore) begin
          if (out_valid_s[i]) begin
            if (out_first_s[i]) begin
              acc_first[i]++;
              if (acc_pay[i] != 0) acc_first_bad[i]++;
            end
            if (out_last_s[i]) begin
              acc_last[i]++;
              if (!frame_done_s[i]) acc_last_bad[i]++;
            end
            if (exp_idx[i] >= exp_stream.size() || out_data_s[i] !== exp_stream[exp_idx[i]])
              data_err[i]++;
            exp_idx[i]++;
            acc_pay[i]++;
          end else if (out_first_s[i] || out_last_s[i] || out_data_s[i] != 8'h00) begin
            stray[i]++;
          end
          if (frame_done_s[i]) begin
            done_t r;
            r.n_pay = acc_pay[i]; r.n_first = acc_first[i]; r.first_bad = acc_first_bad[i];
            r.n_last = acc_last[i]; r.last_bad = acc_last_bad[i];
            r.good = frame_good_s[i]; r.fcs = fcs_error_s[i]; r.lerr = length_error_s[i];
            r.flen = frame_length_s[i];
            if (i == 0) done_a.push_back(r);
            else        done_b.push_back(r);
            acc_pay[i] = 0; acc_first[i] = 0; acc_first_bad[i] = 0;
            acc_last[i] = 0; acc_last_bad[i] = 0;
          end else if (frame_good_s[i] || fcs_error_s[i] || length_error_s[i] ||
                       frame_length_s[i] != 11'd0) begin
            stray[i]++;
          end
        end
      end
    end
  end

  // Frame construction and driving.
  logic [7:0] frame_q[$];

  task automatic build_frame(input int len, input int kind, input bit corrupt);
    logic [31:0] c;
    frame_q.delete();
    if (kind == K_DIGITS) begin
      for (int i = 0; i < 9; i++) frame_q.push_back(8'(8'h31 + i));
      frame_q.push_back(8'h26); frame_q.push_back(8'h39);
      frame_q.push_back(8'hF4); frame_q.push_back(8'hCB);
    end else if (len < 4) begin
      for (int i = 0; i < len; i++) frame_q.push_back(8'(i * 7 + 3));
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
        frame_q.push_back(8'(i * 7 + 3));
        c = crc_step(c, 8'(i * 7 + 3));
      end
      c = ~c;
      frame_q.push_back(c[7:0]);   frame_q.push_back(c[15:8]);
      frame_q.push_back(c[23:16]); frame_q.push_back(c[31:24]);
    end
    if (corrupt) frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ 8'h01;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame_q[i]) begin
      rx_dv = 1'b1; rx_data = frame_q[i];
      @(posedge clock); #1;
    end
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) exp_stream.push_back(frame_q[k]);
  endtask

  task automatic check_frame(input int i, input string tag, input int exp_n,
                             input bit e_good, input bit e_fcs, input bit e_lerr,
                             input int e_flen, input int e_pay, input bit e_last);
    done_t r;
    int    n;
    string p;
    p = $sformatf("%s/%s", tag, (i == 0) ? "min13" : "min64");
    n = (i == 0) ? done_a.size() : done_b.size();
    check({p, "/done_pulses"}, 64'(n), 64'(exp_n));
    if (n > 0) begin
      if (i == 0) r = done_a.pop_front();
      else        r = done_b.pop_front();
      check({p, "/frame_good"},   64'(r.good), 64'(e_good));
      check({p, "/fcs_error"},    64'(r.fcs),  64'(e_fcs));
      check({p, "/length_error"}, 64'(r.lerr), 64'(e_lerr));
      check({p, "/frame_length"}, 64'(r.flen), 64'(e_flen));
      check({p, "/payload_cnt"},  64'(r.n_pay), 64'(e_pay));
      check({p, "/first_cnt"},    64'(r.n_first), 64'((e_pay > 0) ? 1 : 0));
      check({p, "/first_pos"},    64'(r.first_bad), 64'(0));
      check({p, "/last_cnt"},     64'(r.n_last), 64'(e_last));
      check({p, "/last_w_done"},  64'(r.last_bad), 64'(0));
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/%0d/strobes", tag, i),
            64'({out_valid_s[i], out_first_s[i], out_last_s[i], frame_done_s[i],
                 frame_good_s[i], fcs_error_s[i], length_error_s[i]}), 64'(0));
      check($sformatf("%s/%0d/out_data", tag, i), 64'(out_data_s[i]), 64'(0));
      check($sformatf("%s/%0d/frame_length", tag, i), 64'(frame_length_s[i]), 64'(0));
    end
  endtask

  typedef struct {
    string name;
    int    len;
    int    kind;
    bit    corrupt;
    int    exp_pay;
    bit    exp_last;
    int    exp_flen;
    bit    a_good, a_fcs, a_lerr;
    bit    b_good, b_fcs, b_lerr;
  } vec_t;

  vec_t vecs [11];
  int   ev_snap [2];

  initial begin
    //           name        len  kind       cor pay   last flen  a: good fcs len  b: good fcs len
    vecs[0]  = '{"digits",    13, K_DIGITS,  0,     9, 1,   13,  1, 0, 0,  0, 0, 1};
    vecs[1]  = '{"good64",    64, K_PATTERN, 0,    60, 1,   64,  1, 0, 0,  1, 0, 0};
    vecs[2]  = '{"bad64",     64, K_PATTERN, 1,    60, 1,   64,  0, 1, 0,  0, 1, 0};
    vecs[3]  = '{"len63",     63, K_PATTERN, 0,    59, 1,   63,  1, 0, 0,  0, 0, 1};
    vecs[4]  = '{"max1518", 1518, K_PATTERN, 0,  1514, 1, 1518,  1, 0, 0,  1, 0, 0};
    vecs[5]  = '{"over1519",1519, K_PATTERN, 0,  1513, 0, 1519,  0, 0, 1,  0, 0, 1};
    vecs[6]  = '{"long1600",1600, K_PATTERN, 0,  1513, 0, 1600,  0, 0, 1,  0, 0, 1};
    vecs[7]  = '{"sat2100", 2100, K_PATTERN, 0,  1513, 0, 2047,  0, 0, 1,  0, 0, 1};
    vecs[8]  = '{"runt3",      3, K_PATTERN, 0,     0, 0,    3,  0, 0, 1,  0, 0, 1};
    vecs[9]  = '{"runt4",      4, K_PATTERN, 0,     0, 0,    4,  0, 0, 1,  0, 0, 1};
    vecs[10] = '{"one5",       5, K_PATTERN, 0,     1, 1,    5,  0, 0, 1,  0, 0, 1};

    for (int i = 0; i < 2; i++) begin
      data_err[i] = 0; stray[i] = 0; ev_cnt[i] = 0; exp_idx[i] = 0;
    end

    // Reset state.
    reset_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");

    // A frame already in flight at reset release must be ignored.
    rx_dv = 1'b1; rx_data = 8'hA5;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) ev_snap[i] = ev_cnt[i];
    for (int k = 0; k < 30; k++) begin
      rx_data = 8'(k * 13 + 1);
      @(posedge clock); #1;
    end
    check_quiet("partial_after_reset");
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("partial_after_reset/%0d/events", i), 64'(ev_cnt[i] - ev_snap[i]), 64'(0));
    check("idle_crc_clear", 64'(crc_clear_s), 64'(2'b11));

    // Table-driven frames.
    for (int v = 0; v < 11; v++) begin
      build_frame(vecs[v].len, vecs[v].kind, vecs[v].corrupt);
      push_expected(vecs[v].exp_pay);
      send_frame(4);
      check_frame(0, vecs[v].name, 1, vecs[v].a_good, vecs[v].a_fcs, vecs[v].a_lerr,
                  vecs[v].exp_flen, vecs[v].exp_pay, vecs[v].exp_last);
      check_frame(1, vecs[v].name, 1, vecs[v].b_good, vecs[v].b_fcs, vecs[v].b_lerr,
                  vecs[v].exp_flen, vecs[v].exp_pay, vecs[v].exp_last);
    end

    // Back-to-back frames with a single idle cycle between them.
    build_frame(64, K_PATTERN, 1'b0);
    push_expected(60);
    send_frame(1);
    build_frame(64, K_PATTERN, 1'b1);
    push_expected(60);
    send_frame(4);
    for (int i = 0; i < 2; i++) begin
      check_frame(i, "b2b_first", 2, 1, 0, 0, 64, 60, 1);
      check_frame(i, "b2b_second", 1, 0, 1, 0, 64, 60, 1);
    end

    // Reset pulsed at byte 20 of a 100-byte frame.
    build_frame(100, K_PATTERN, 1'b0);
    mon_ignore = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rx_dv = 1'b1; rx_data = frame_q[k];
      if (k == 19) begin
        #2 reset_n = 1'b0;
        #1 check_quiet("async_reset");
        mon_ignore = 1'b0;
      end
      @(posedge clock); #1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) ev_snap[i] = ev_cnt[i];
    for (int k = 20; k < 100; k++) begin
      rx_data = frame_q[k];
      @(posedge clock); #1;
    end
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (4) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("after_reset_tail/%0d/events", i), 64'(ev_cnt[i] - ev_snap[i]), 64'(0));

    // Next frame after the reset is checked normally.
    build_frame(13, K_DIGITS, 1'b0);
    push_expected(9);
    send_frame(4);
    check_frame(0, "post_reset_digits", 1, 1, 0, 0, 13, 9, 1);
    check_frame(1, "post_reset_digits", 1, 0, 0, 1, 13, 9, 1);

    // Whole-run stream checks.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("final/%0d/payload_data_errors", i), 64'(data_err[i]), 64'(0));
      check($sformatf("final/%0d/payload_bytes_seen", i), 64'(exp_idx[i]), 64'(exp_stream.size()));
      check($sformatf("final/%0d/stray_strobes", i), 64'(stray[i]), 64'(0));
    end
    check("final/leftover_done_min13", 64'(done_a.size()), 64'(0));
    check("final/leftover_done_min64", 64'(done_b.size()), 64'(0));
    check("final/crc_port_errors", 64'(clr_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
